// File: rtl/sc_ctrl_sequencer_if.sv
// rtl/sc_ctrl_sequencer_if.sv - control/flag bundle between the sequencer and the micro-datapath
//
// Signals (direction seen from the sequencer, modport master):
//   out decoderclearselection / decoderloadselection : register clear/load selects, all-ones = none
//   out muxselectionBUSA / muxselectionBUSB          : bus source selects
//   out aluselection                                 : ALU operation
//   out regSHIFTERclear / regSHIFTERload (active low), regSHIFTERshiftselection
//   in  overflow / carry / negative / zero flags (active low)
interface sc_ctrl_sequencer_if #(
    parameter int DATAWIDTH_DECODER_SELECTION    = 4,
    parameter int DATAWIDTH_MUX_SELECTION        = 3,
    parameter int DATAWIDTH_ALU_SELECTION        = 4,
    parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2
) ();
    logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_CTRLSEQ_decoderclearselection_OutBUS;
    logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_CTRLSEQ_decoderloadselection_OutBUS;
    logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_CTRLSEQ_muxselectionBUSA_OutBUS;
    logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_CTRLSEQ_muxselectionBUSB_OutBUS;
    logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_CTRLSEQ_aluselection_OutBUS;
    logic                                      SC_CTRLSEQ_regSHIFTERclear_OutLow;
    logic                                      SC_CTRLSEQ_regSHIFTERload_OutLow;
    logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_CTRLSEQ_regSHIFTERshiftselection_OutBUS;
    logic                                      SC_CTRLSEQ_overflow_InLow;
    logic                                      SC_CTRLSEQ_carry_InLow;
    logic                                      SC_CTRLSEQ_negative_InLow;
    logic                                      SC_CTRLSEQ_zero_InLow;

    modport master (
        output SC_CTRLSEQ_decoderclearselection_OutBUS,
        output SC_CTRLSEQ_decoderloadselection_OutBUS,
        output SC_CTRLSEQ_muxselectionBUSA_OutBUS,
        output SC_CTRLSEQ_muxselectionBUSB_OutBUS,
        output SC_CTRLSEQ_aluselection_OutBUS,
        output SC_CTRLSEQ_regSHIFTERclear_OutLow,
        output SC_CTRLSEQ_regSHIFTERload_OutLow,
        output SC_CTRLSEQ_regSHIFTERshiftselection_OutBUS,
        input  SC_CTRLSEQ_overflow_InLow,
        input  SC_CTRLSEQ_carry_InLow,
        input  SC_CTRLSEQ_negative_InLow,
        input  SC_CTRLSEQ_zero_InLow
    );

    modport slave (
        input  SC_CTRLSEQ_decoderclearselection_OutBUS,
        input  SC_CTRLSEQ_decoderloadselection_OutBUS,
        input  SC_CTRLSEQ_muxselectionBUSA_OutBUS,
        input  SC_CTRLSEQ_muxselectionBUSB_OutBUS,
        input  SC_CTRLSEQ_aluselection_OutBUS,
        input  SC_CTRLSEQ_regSHIFTERclear_OutLow,
        input  SC_CTRLSEQ_regSHIFTERload_OutLow,
        input  SC_CTRLSEQ_regSHIFTERshiftselection_OutBUS,
        output SC_CTRLSEQ_overflow_InLow,
        output SC_CTRLSEQ_carry_InLow,
        output SC_CTRLSEQ_negative_InLow,
        output SC_CTRLSEQ_zero_InLow
    );
endinterface

// File: rtl/sc_ctrl_sequencer.sv
// rtl/sc_ctrl_sequencer.sv - Moore sequencer running ACC = FIX0 x FIX1 then load/shift on the micro-datapath
//
// Ports:
//   SC_CTRLSEQ_CLOCK_50          in  : clock
//   SC_CTRLSEQ_RESET_InLow       in  : synchronous active-low reset
//   SC_CTRLSEQ_start_InHigh      in  : run request, sampled only in IDLE
//   SC_CTRLSEQ_busy_OutHigh      out : high in every state except IDLE
//   SC_CTRLSEQ_done_OutHigh      out : one-cycle pulse on normal completion
//   SC_CTRLSEQ_error_OutHigh     out : sticky overflow error, cleared by accepted start or reset
//   dp                           if  : datapath control outputs / flag inputs (master modport)
//   SC_CTRLSEQ_cyclecount_OutBUS out : busy-cycle count of the last finished run
//                                      (present only with SC_CTRLSEQ_CYCLECOUNT_EN defined)
module sc_ctrl_sequencer #(
    parameter int DATAWIDTH_DECODER_SELECTION    = 4,
    parameter int DATAWIDTH_MUX_SELECTION        = 3,
    parameter int DATAWIDTH_ALU_SELECTION        = 4,
    parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
    parameter int SHIFT_COUNT                    = 1
) (
    input  logic SC_CTRLSEQ_CLOCK_50,
    input  logic SC_CTRLSEQ_RESET_InLow,
    input  logic SC_CTRLSEQ_start_InHigh,
    output logic SC_CTRLSEQ_busy_OutHigh,
    output logic SC_CTRLSEQ_done_OutHigh,
    output logic SC_CTRLSEQ_error_OutHigh,
    sc_ctrl_sequencer_if.master dp
`ifdef SC_CTRLSEQ_CYCLECOUNT_EN
    , output logic [15:0] SC_CTRLSEQ_cyclecount_OutBUS
`endif
);
    localparam int DW = DATAWIDTH_DECODER_SELECTION;
    localparam int MW = DATAWIDTH_MUX_SELECTION;
    localparam int AW = DATAWIDTH_ALU_SELECTION;
    localparam int SW = DATAWIDTH_REGSHIFTER_SELECTION;

    localparam logic [DW-1:0] SEL_NONE = {DW{1'b1}};
    localparam logic [DW-1:0] SEL_R0   = DW'(0);
    localparam logic [DW-1:0] SEL_R1   = DW'(1);
    localparam logic [MW-1:0] MUX_R0   = MW'(0);
    localparam logic [MW-1:0] MUX_R1   = MW'(1);
    localparam logic [MW-1:0] MUX_FIX0 = MW'(4);
    localparam logic [MW-1:0] MUX_FIX1 = MW'(5);
    localparam logic [AW-1:0] ALU_PASS = AW'(0);
    localparam logic [AW-1:0] ALU_ADD  = AW'(1);
    localparam logic [AW-1:0] ALU_DEC  = AW'(4);
    localparam logic [SW-1:0] SH_HOLD  = SW'(0);
    localparam logic [SW-1:0] SH_LEFT  = SW'(1);
    localparam logic [3:0]    SHIFT_N  = 4'(SHIFT_COUNT);

    typedef enum logic [3:0] {
        S_IDLE, S_CLR0, S_CLR1, S_LDCNT, S_ACC, S_DEC, S_SHLD, S_SHIFT, S_DONE, S_ERR
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] shcnt_q, shcnt_d;
    logic       error_q, error_d;

    // Carry and negative play no part in this microprogram.
    logic unused_flags;
    assign unused_flags = dp.SC_CTRLSEQ_carry_InLow ^ dp.SC_CTRLSEQ_negative_InLow;

    always_ff @(posedge SC_CTRLSEQ_CLOCK_50) begin
        if (!SC_CTRLSEQ_RESET_InLow) begin
            state_q <= S_IDLE;
            shcnt_q <= 4'd0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shcnt_q <= shcnt_d;
            error_q <= error_d;
        end
    end

    // Next state plus Moore outputs; outputs depend on state_q only.
    always_comb begin
        state_d = state_q;
        shcnt_d = shcnt_q;
        error_d = error_q;
        dp.SC_CTRLSEQ_decoderclearselection_OutBUS    = SEL_NONE;
        dp.SC_CTRLSEQ_decoderloadselection_OutBUS     = SEL_NONE;
        dp.SC_CTRLSEQ_muxselectionBUSA_OutBUS         = MUX_R0;
        dp.SC_CTRLSEQ_muxselectionBUSB_OutBUS         = MUX_R0;
        dp.SC_CTRLSEQ_aluselection_OutBUS             = ALU_PASS;
        dp.SC_CTRLSEQ_regSHIFTERclear_OutLow          = 1'b1;
        dp.SC_CTRLSEQ_regSHIFTERload_OutLow           = 1'b1;
        dp.SC_CTRLSEQ_regSHIFTERshiftselection_OutBUS = SH_HOLD;
        case (state_q)
            S_IDLE: begin
                if (SC_CTRLSEQ_start_InHigh) begin
                    state_d = S_CLR0;
                    error_d = 1'b0;
                end
            end
            S_CLR0: begin
                dp.SC_CTRLSEQ_decoderclearselection_OutBUS = SEL_R0;
                state_d = S_CLR1;
            end
            S_CLR1: begin
                dp.SC_CTRLSEQ_decoderclearselection_OutBUS = SEL_R1;
                dp.SC_CTRLSEQ_regSHIFTERclear_OutLow       = 1'b0;
                state_d = S_LDCNT;
            end
            S_LDCNT: begin
                // R0 <= FIX0; a zero flag here means the product is trivially 0.
                dp.SC_CTRLSEQ_muxselectionBUSA_OutBUS     = MUX_FIX0;
                dp.SC_CTRLSEQ_aluselection_OutBUS         = ALU_PASS;
                dp.SC_CTRLSEQ_decoderloadselection_OutBUS = SEL_R0;
                state_d = !dp.SC_CTRLSEQ_zero_InLow ? S_SHLD : S_ACC;
            end
            S_ACC: begin
                dp.SC_CTRLSEQ_muxselectionBUSA_OutBUS     = MUX_R1;
                dp.SC_CTRLSEQ_muxselectionBUSB_OutBUS     = MUX_FIX1;
                dp.SC_CTRLSEQ_aluselection_OutBUS         = ALU_ADD;
                dp.SC_CTRLSEQ_decoderloadselection_OutBUS = SEL_R1;
                if (!dp.SC_CTRLSEQ_overflow_InLow) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end else begin
                    state_d = S_DEC;
                end
            end
            S_DEC: begin
                // Zero flag reflects R0-1, so the loop exits after FIX0 additions.
                dp.SC_CTRLSEQ_muxselectionBUSA_OutBUS     = MUX_R0;
                dp.SC_CTRLSEQ_aluselection_OutBUS         = ALU_DEC;
                dp.SC_CTRLSEQ_decoderloadselection_OutBUS = SEL_R0;
                state_d = !dp.SC_CTRLSEQ_zero_InLow ? S_SHLD : S_ACC;
            end
            S_SHLD: begin
                dp.SC_CTRLSEQ_muxselectionBUSA_OutBUS = MUX_R1;
                dp.SC_CTRLSEQ_aluselection_OutBUS     = ALU_PASS;
                dp.SC_CTRLSEQ_regSHIFTERload_OutLow   = 1'b0;
                shcnt_d = SHIFT_N;
                state_d = (SHIFT_N == 4'd0) ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
                dp.SC_CTRLSEQ_regSHIFTERshiftselection_OutBUS = SH_LEFT;
                shcnt_d = shcnt_q - 4'd1;
                if (shcnt_q == 4'd1) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign SC_CTRLSEQ_busy_OutHigh  = (state_q != S_IDLE);
    assign SC_CTRLSEQ_done_OutHigh  = (state_q == S_DONE);
    assign SC_CTRLSEQ_error_OutHigh = error_q;

`ifdef SC_CTRLSEQ_CYCLECOUNT_EN
    logic [15:0] cyc_q;
    logic [15:0] cycout_q;
    logic [15:0] cyc_inc;

    assign cyc_inc = (cyc_q == 16'hFFFF) ? 16'hFFFF : cyc_q + 16'd1;

    // The final DONE/ERR cycle is itself busy, so the published value includes it.
    always_ff @(posedge SC_CTRLSEQ_CLOCK_50) begin
        if (!SC_CTRLSEQ_RESET_InLow) begin
            cyc_q    <= 16'd0;
            cycout_q <= 16'd0;
        end else if (state_q == S_IDLE) begin
            if (SC_CTRLSEQ_start_InHigh) cyc_q <= 16'd0;
        end else begin
            cyc_q <= cyc_inc;
            if (state_q == S_DONE || state_q == S_ERR) cycout_q <= cyc_inc;
        end
    end

    assign SC_CTRLSEQ_cyclecount_OutBUS = cycout_q;
`endif
endmodule

// File: tb/tb_sc_ctrl_sequencer.sv
// tb/tb_sc_ctrl_sequencer.sv - self-checking bench with a behavioural datapath and run-level reference model
module tb_sc_ctrl_sequencer;
    localparam int SC = 1;

    logic clk = 1'b0;
    logic resetn;
    logic start;
    logic busy, done, error;
`ifdef SC_CTRLSEQ_CYCLECOUNT_EN
    logic [15:0] cyclecount;
`endif

    always #5 clk = ~clk;

    sc_ctrl_sequencer_if dp_if ();

    sc_ctrl_sequencer #(.SHIFT_COUNT(SC)) dut (
        .SC_CTRLSEQ_CLOCK_50    (clk),
        .SC_CTRLSEQ_RESET_InLow (resetn),
        .SC_CTRLSEQ_start_InHigh(start),
        .SC_CTRLSEQ_busy_OutHigh(busy),
        .SC_CTRLSEQ_done_OutHigh(done),
        .SC_CTRLSEQ_error_OutHigh(error),
        .dp                     (dp_if.master)
`ifdef SC_CTRLSEQ_CYCLECOUNT_EN
        , .SC_CTRLSEQ_cyclecount_OutBUS(cyclecount)
`endif
    );

    // Behavioural datapath: R0 counter, R1 accumulator, shift register, FIX0/FIX1 constants.
    logic [15:0] fix0, fix1, r0, r1, shreg;
    int          ovf_at, acc_seen;
    logic [16:0] busa, busb, busc;

    function automatic logic [16:0] mux(input logic [2:0] s);
        case (s)
            3'd0:    return {1'b0, r0};
            3'd1:    return {1'b0, r1};
            3'd4:    return {1'b0, fix0};
            3'd5:    return {1'b0, fix1};
            default: return 17'd0;
        endcase
    endfunction

    always_comb begin
        busa = mux(dp_if.SC_CTRLSEQ_muxselectionBUSA_OutBUS);
        busb = mux(dp_if.SC_CTRLSEQ_muxselectionBUSB_OutBUS);
        case (dp_if.SC_CTRLSEQ_aluselection_OutBUS)
            4'b0000: busc = busa;
            4'b0001: busc = busa + busb;
            4'b0100: busc = busa - 17'd1;
            default: busc = 17'd0;
        endcase
        dp_if.SC_CTRLSEQ_zero_InLow     = (busc[15:0] != 16'd0);
        dp_if.SC_CTRLSEQ_overflow_InLow = !((dp_if.SC_CTRLSEQ_aluselection_OutBUS == 4'b0001)
                                            && (busc[16] || (ovf_at != 0 && acc_seen + 1 == ovf_at)));
        dp_if.SC_CTRLSEQ_carry_InLow    = 1'b1;
        dp_if.SC_CTRLSEQ_negative_InLow = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r0 <= 16'd0; r1 <= 16'd0; shreg <= 16'd0; acc_seen <= 0;
        end else begin
            if (dp_if.SC_CTRLSEQ_decoderclearselection_OutBUS == 4'd0) r0 <= 16'd0;
            if (dp_if.SC_CTRLSEQ_decoderclearselection_OutBUS == 4'd1) r1 <= 16'd0;
            if (dp_if.SC_CTRLSEQ_decoderloadselection_OutBUS == 4'd0) r0 <= busc[15:0];
            if (dp_if.SC_CTRLSEQ_decoderloadselection_OutBUS == 4'd1) r1 <= busc[15:0];
            if (!dp_if.SC_CTRLSEQ_regSHIFTERclear_OutLow) shreg <= 16'd0;
            else if (!dp_if.SC_CTRLSEQ_regSHIFTERload_OutLow) shreg <= busc[15:0];
            else if (dp_if.SC_CTRLSEQ_regSHIFTERshiftselection_OutBUS == 2'b01) shreg <= shreg << 1;
            else if (dp_if.SC_CTRLSEQ_regSHIFTERshiftselection_OutBUS == 2'b10) shreg <= shreg >> 1;
            if (dp_if.SC_CTRLSEQ_decoderclearselection_OutBUS == 4'd0) acc_seen <= 0;
            else if (dp_if.SC_CTRLSEQ_aluselection_OutBUS == 4'b0001) acc_seen <= acc_seen + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_clrsel"}, int'(dp_if.SC_CTRLSEQ_decoderclearselection_OutBUS), 15);
        check({tag, "_ldsel"}, int'(dp_if.SC_CTRLSEQ_decoderloadselection_OutBUS), 15);
        check({tag, "_shclr_ld"}, int'({dp_if.SC_CTRLSEQ_regSHIFTERclear_OutLow,
                                        dp_if.SC_CTRLSEQ_regSHIFTERload_OutLow}), 3);
        check({tag, "_mux_alu_sh"}, int'({dp_if.SC_CTRLSEQ_muxselectionBUSA_OutBUS,
                                          dp_if.SC_CTRLSEQ_muxselectionBUSB_OutBUS,
                                          dp_if.SC_CTRLSEQ_aluselection_OutBUS,
                                          dp_if.SC_CTRLSEQ_regSHIFTERshiftselection_OutBUS}), 0);
    endtask

    // Reference model: busy-cycle length of one run, derived from the microprogram steps.
    function automatic int exp_len(input int f0, input int ovf);
        if (ovf >= 1 && ovf <= f0) return 3 + 2 * (ovf - 1) + 1 + 1;
        if (f0 == 0) return 3 + 1 + SC + 1;
        return 3 + 2 * f0 + 1 + SC + 1;
    endfunction

    // Pulses start once, then samples every busy cycle on the falling edge.
    task automatic run_one(input logic [15:0] f0, input logic [15:0] f1, input int ovf,
                           output int cycles, output int done_cnt, output int done_last,
                           output int err_first);
        fix0 = f0; fix1 = f1; ovf_at = ovf;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cycles = 0; done_cnt = 0; done_last = 0; err_first = int'(error);
        while (busy && cycles < 300) begin
            cycles++;
            if (done) done_cnt++;
            done_last = int'(done);
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [15:0] fix0;
        logic [15:0] fix1;
        int          ovf_at;
        int          exp_cycles;
        int          exp_err;
        int          exp_sh;
    } vec_t;

    vec_t vecs[7];

    task automatic run_and_check(input string tag, input logic [15:0] f0, input logic [15:0] f1,
                                 input int ovf, input int ec, input int ee, input int es);
        int cyc, dc, dl, ef;
        run_one(f0, f1, ovf, cyc, dc, dl, ef);
        check({tag, "_cycles"}, cyc, ec);
        check({tag, "_err_cleared_on_start"}, ef, 0);
        check({tag, "_error"}, int'(error), ee);
        check({tag, "_done_pulses"}, dc, ee ? 0 : 1);
        if (!ee) begin
            check({tag, "_done_last"}, dl, 1);
            check({tag, "_shreg"}, int'(shreg), es);
        end
`ifdef SC_CTRLSEQ_CYCLECOUNT_EN
        check({tag, "_cyclecount"}, int'(cyclecount), ec);
`endif
    endtask

    initial begin
        int cyc, dc, dl, ef, mism, dones, n;
        vecs[0] = '{16'd9,  16'd15,  0, 24, 0, 270};
        vecs[1] = '{16'd0,  16'd77,  0,  6, 0,   0};
        vecs[2] = '{16'd1,  16'd1,   0,  8, 0,   2};
        vecs[3] = '{16'd9,  16'd15,  3,  9, 1,   0};
        vecs[4] = '{16'd5,  16'd100, 0, 16, 0, 1000};
        vecs[5] = '{16'd4,  16'd3,   1,  5, 1,   0};
        vecs[6] = '{16'd0,  16'd5,   2,  6, 0,   0};

        resetn = 1'b0; start = 1'b0; fix0 = 0; fix1 = 0; ovf_at = 0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_done", int'(done), 0);
        check("reset_error", int'(error), 0);
        resetn = 1'b1;

        foreach (vecs[i])
            run_and_check($sformatf("vec%0d", i), vecs[i].fix0, vecs[i].fix1, vecs[i].ovf_at,
                          vecs[i].exp_cycles, vecs[i].exp_err, vecs[i].exp_sh);

        for (int k = 0; k < 20; k++) begin
            int f0, f1, ov, ee;
            f0 = $urandom_range(0, 12);
            f1 = $urandom_range(0, 300);
            ov = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 14) : 0;
            ee = (ov >= 1 && ov <= f0) ? 1 : 0;
            run_and_check($sformatf("rnd%0d", k), 16'(f0), 16'(f1), ov, exp_len(f0, ov), ee,
                          ((f0 * f1) << SC) & 32'hFFFF);
        end

        // Reset low for two cycles in the middle of the ACC loop.
        fix0 = 16'd9; fix1 = 16'd15; ovf_at = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (acc_seen < 3 && n < 100) begin @(negedge clk); n++; end
        check("midrun_reach_acc", int'(n < 100), 1);
        while (dp_if.SC_CTRLSEQ_aluselection_OutBUS != 4'b0001 && n < 100) begin
            @(negedge clk); n++;
        end
        resetn = 1'b0;
        @(negedge clk);
        check_idle_outputs("midrun_reset");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("midrun_stays_idle", int'(busy), 0);

        // Error sticky in IDLE, cleared by reset; reset wins over a coincident start.
        run_one(16'd4, 16'd3, 1, cyc, dc, dl, ef);
        repeat (2) @(negedge clk);
        check("err_sticky_idle", int'(error), 1);
        resetn = 1'b0; start = 1'b1;
        @(negedge clk);
        check("reset_with_start_busy", int'(busy), 0);
        check("reset_clears_error", int'(error), 0);
        resetn = 1'b1; start = 1'b0;
        @(negedge clk);

        // Start held high for 40 cycles, FIX0=1: 8 busy cycles then one IDLE cycle, repeating.
        fix0 = 16'd1; fix1 = 16'd7; ovf_at = 0;
        start = 1'b1;
        mism = 0; dones = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (int'(busy) != ((((k - 1) % 9) < 8) ? 1 : 0)) mism++;
            if (int'(done) != ((((k - 1) % 9) == 7) ? 1 : 0)) mism++;
            if (done) dones++;
        end
        start = 1'b0;
        check("held_start_pattern", mism, 0);
        check("held_start_dones", dones, 4);
        n = 0;
        while (busy && n < 50) begin @(negedge clk); n++; end
        check("held_start_drain", int'(busy), 0);

        // Start pulses while busy must not extend or repeat the run.
        fix0 = 16'd3; fix1 = 16'd11; ovf_at = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0; dc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            if (done) dc++;
            start = (cyc == 5 || cyc == 12) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_start_cycles", cyc, exp_len(3, 0));
        check("busy_start_dones", dc, 1);
        check("busy_start_shreg", int'(shreg), (33 << SC) & 16'hFFFF);
        mism = 0;
        repeat (3) begin @(negedge clk); if (busy) mism++; end
        check("busy_start_no_rerun", mism, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
